// File: rtl/dbg_pkg.sv
// Shared definitions for the debug packet engine: opcodes, error-bit
// positions, FSM state encoding and the bits-to-wire-bytes helper.
package dbg_pkg;

  localparam logic [7:0] OP_ECHO   = 8'h00;
  localparam logic [7:0] OP_MEM_RD = 8'h01;
  localparam logic [7:0] OP_MEM_WR = 8'h02;
  localparam logic [7:0] OP_ERR_RD = 8'h03;

  localparam int ERR_PARITY = 0;
  localparam int ERR_OPCODE = 1;
  localparam int ERR_RSVD   = 2;

  typedef enum logic [3:0] {
    S_DECODE,
    S_ECHO_CNT,
    S_ECHO_DATA,
    S_HDR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_SEND,
    S_WR_DATA,
    S_ERR_SEND
  } state_t;

  function automatic int ceil_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/dbg_le_shift.sv
// Little-endian byte accumulator: each shift drops the incoming byte into the
// next lane; value_o already includes the byte being shifted this cycle.
module dbg_le_shift
  import dbg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic [7:0]       byte_i,
  output logic             last_o,
  output logic [WIDTH-1:0] value_o
);

  localparam int NB = ceil_bytes(WIDTH);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [NB*8-1:0] acc_q, acc_d, acc_in;
  logic [CW-1:0]   idx_q, idx_d;

  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_lane
    assign acc_in[gi*8 +: 8] = (idx_q == CW'(gi)) ? byte_i : acc_q[gi*8 +: 8];
  end

  assign value_o = acc_in[WIDTH-1:0];
  assign last_o  = (idx_q == CW'(NB - 1));

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (shift_i) begin
      acc_d = acc_in;
      idx_d = idx_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/dbg_pkt_engine.sv
// Debug packet engine: decodes packets from the UART rx FIFO, performs echo,
// byte-wide debug-bus reads/writes and error readback, replies via tx FIFO.
module dbg_pkt_engine
  import dbg_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_empty,
  input  logic                  parity_err,
  output logic                  rd_en,
  output logic [7:0]            tx_data,
  output logic                  wr_en,
  input  logic                  tx_full,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_wr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rdata,
  output logic [2:0]            err_code
);

  state_t                state_q, state_d;
  logic                  is_wr_q, is_wr_d;
  logic                  hdr_cnt_q, hdr_cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            hold_q, hold_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [2:0]            err_q, err_d;
  logic [2:0]            lat_q, lat_d;

  logic                  pop, sh_clr, addr_shift, cnt_shift;
  logic                  addr_last, cnt_last;
  logic [ADDR_WIDTH-1:0] addr_val;
  logic [CNT_WIDTH-1:0]  cnt_val;

  dbg_le_shift #(.WIDTH(ADDR_WIDTH)) u_addr_sh (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sh_clr),
    .shift_i (addr_shift),
    .byte_i  (rx_data),
    .last_o  (addr_last),
    .value_o (addr_val)
  );

  dbg_le_shift #(.WIDTH(CNT_WIDTH)) u_cnt_sh (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sh_clr),
    .shift_i (cnt_shift),
    .byte_i  (rx_data),
    .last_o  (cnt_last),
    .value_o (cnt_val)
  );

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    hdr_cnt_d  = hdr_cnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = 1'b0;
    mem_wr_d   = 1'b0;
    mem_rd_d   = 1'b0;
    err_d      = err_q;
    lat_d      = lat_q;
    pop        = 1'b0;
    sh_clr     = 1'b0;
    addr_shift = 1'b0;
    cnt_shift  = 1'b0;

    // The address advances only after the write strobe has been presented.
    if (mem_wr_q) addr_d = addr_q + ADDR_WIDTH'(1);

    case (state_q)
      S_DECODE: begin
        if (!rx_empty) begin
          pop    = 1'b1;
          sh_clr = 1'b1;
          case (rx_data)
            OP_ECHO:   state_d = S_ECHO_CNT;
            OP_MEM_RD, OP_MEM_WR: begin
              state_d   = S_HDR;
              is_wr_d   = (rx_data == OP_MEM_WR);
              hdr_cnt_d = 1'b0;
            end
            OP_ERR_RD: state_d = S_ERR_SEND;
            default:   err_d[ERR_OPCODE] = 1'b1;
          endcase
        end
      end
      S_ECHO_CNT: begin
        if (!rx_empty) begin
          pop       = 1'b1;
          cnt_shift = 1'b1;
          if (cnt_last) begin
            cnt_d   = cnt_val;
            state_d = (cnt_val == '0) ? S_DECODE : S_ECHO_DATA;
          end
        end
      end
      S_ECHO_DATA: begin
        if (!rx_empty && !tx_full) begin
          pop       = 1'b1;
          tx_data_d = rx_data;
          wr_en_d   = 1'b1;
          cnt_d     = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) state_d = S_DECODE;
        end
      end
      S_HDR: begin
        if (!rx_empty) begin
          pop = 1'b1;
          if (!hdr_cnt_q) begin
            addr_shift = 1'b1;
            if (addr_last) begin
              addr_d    = addr_val;
              hdr_cnt_d = 1'b1;
            end
          end else begin
            cnt_shift = 1'b1;
            if (cnt_last) begin
              cnt_d = cnt_val;
              if (cnt_val == '0) state_d = S_DECODE;
              else               state_d = is_wr_q ? S_WR_DATA : S_RD_ISSUE;
            end
          end
        end
      end
      S_RD_ISSUE: begin
        mem_rd_d = 1'b1;
        lat_d    = '0;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // lat_q counts cycles since the strobe was on the bus.
        if (lat_q == 3'(RD_LATENCY)) begin
          hold_d  = mem_rdata;
          state_d = S_RD_SEND;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_RD_SEND: begin
        if (!tx_full) begin
          tx_data_d = hold_q;
          wr_en_d   = 1'b1;
          addr_d    = addr_q + ADDR_WIDTH'(1);
          cnt_d     = cnt_q - CNT_WIDTH'(1);
          state_d   = (cnt_q == CNT_WIDTH'(1)) ? S_DECODE : S_RD_ISSUE;
        end
      end
      S_WR_DATA: begin
        if (!rx_empty) begin
          pop      = 1'b1;
          wdata_d  = rx_data;
          mem_wr_d = 1'b1;
          cnt_d    = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) state_d = S_DECODE;
        end
      end
      S_ERR_SEND: begin
        if (!tx_full) begin
          tx_data_d = {5'b0, err_q};
          wr_en_d   = 1'b1;
          err_d     = '0;
          state_d   = S_DECODE;
        end
      end
      default: state_d = S_DECODE;
    endcase

    // A parity error arriving alongside the clear must survive it.
    if (parity_err) err_d[ERR_PARITY] = 1'b1;
    err_d[ERR_RSVD] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_DECODE;
      is_wr_q   <= 1'b0;
      hdr_cnt_q <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hold_q    <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      err_q     <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      hdr_cnt_q <= hdr_cnt_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      tx_data_q <= tx_data_d;
      wr_en_q   <= wr_en_d;
      mem_wr_q  <= mem_wr_d;
      mem_rd_q  <= mem_rd_d;
      err_q     <= err_d;
      lat_q     <= lat_d;
    end
  end

  assign rd_en     = pop & ~rst;
  assign tx_data   = tx_data_q;
  assign wr_en     = wr_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_dbg_pkt_engine.sv
// Scoreboard bench for dbg_pkt_engine: stimulus queues expected tx bytes,
// bus writes and point checks; a negedge monitor consumes and compares them.
module tb_dbg_pkt_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        parity_err;
  logic        rd_en;
  logic [7:0]  tx_data;
  logic        wr_en;
  logic        tx_full;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  dbg_pkt_engine #(.ADDR_WIDTH(16), .CNT_WIDTH(16), .RD_LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .parity_err (parity_err),
    .rd_en      (rd_en),
    .tx_data    (tx_data),
    .wr_en      (wr_en),
    .tx_full    (tx_full),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .err_code   (err_code)
  );

  // rx FIFO model: stimulus owns wr_ptr, the FIFO process owns rd_ptr.
  logic [7:0] rx_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rx_empty = (rd_ptr == wr_ptr);
  assign rx_data  = rx_mem[rd_ptr[7:0]];

  always @(posedge clk) begin
    if (rd_en) rd_ptr <= rd_ptr + 1;
  end

  // Debug memory with a two-cycle read pipeline; 8'hEE outside the valid slot.
  logic [7:0] mem [0:65535];
  logic [7:0] rd_d1, rd_d2;
  logic       rd_v1 = 1'b0, rd_v2 = 1'b0;
  assign mem_rdata = rd_v2 ? rd_d2 : 8'hEE;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    rd_v1 <= mem_rd;
    rd_d1 <= mem[mem_addr];
    rd_v2 <= rd_v1;
    rd_d2 <= rd_d1;
  end

  // Scoreboards: written by stimulus (the _wr side), consumed by the monitor.
  logic [7:0]  exp_tx [0:255];
  int          exp_tx_wr = 0, exp_tx_rd = 0;
  logic [15:0] exp_ma [0:63];
  logic [7:0]  exp_md [0:63];
  int          exp_mw_wr = 0, exp_mw_rd = 0;
  string       req_name [0:127];
  logic [63:0] req_act [0:127];
  logic [63:0] req_exp [0:127];
  int          req_wr = 0, req_rd = 0;
  logic        done = 1'b0;

  int errors = 0;
  int checks = 0;
  int cycles = 0;

  always @(negedge clk) begin
    cycles++;
    if (wr_en) begin
      checks++;
      if (exp_tx_rd == exp_tx_wr) begin
        errors++;
        $display("FAIL tx_unexpected: got %02h, none expected", tx_data);
      end else begin
        if (tx_data !== exp_tx[exp_tx_rd]) begin
          errors++;
          $display("FAIL tx_byte[%0d]: got %02h expected %02h", exp_tx_rd, tx_data, exp_tx[exp_tx_rd]);
        end else
          $display("tx[%0d] %02h ok", exp_tx_rd, tx_data);
        exp_tx_rd++;
      end
    end
    if (mem_wr) begin
      checks++;
      if (exp_mw_rd == exp_mw_wr) begin
        errors++;
        $display("FAIL memwr_unexpected: got addr %04h data %02h", mem_addr, mem_wdata);
      end else begin
        if (mem_addr !== exp_ma[exp_mw_rd] || mem_wdata !== exp_md[exp_mw_rd]) begin
          errors++;
          $display("FAIL memwr[%0d]: got %04h/%02h expected %04h/%02h", exp_mw_rd,
                   mem_addr, mem_wdata, exp_ma[exp_mw_rd], exp_md[exp_mw_rd]);
        end else
          $display("memwr[%0d] %04h <= %02h ok", exp_mw_rd, mem_addr, mem_wdata);
        exp_mw_rd++;
      end
    end
    if (rd_en) begin
      checks++;
      if (rx_empty) begin
        errors++;
        $display("FAIL pop_when_empty: rd_en=1 rx_empty=1 required rd_en=0");
      end
    end
    while (req_rd < req_wr) begin
      checks++;
      if (req_act[req_rd] !== req_exp[req_rd]) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", req_name[req_rd], req_act[req_rd], req_exp[req_rd]);
      end else
        $display("check %s = %0h ok", req_name[req_rd], req_act[req_rd]);
      req_rd++;
    end
    if (done || cycles > 20000) begin
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL watchdog: got %0d cycles, required completion", cycles);
      end
      checks++;
      if (exp_tx_rd != exp_tx_wr) begin
        errors++;
        $display("FAIL tx_drain: got %0d bytes expected %0d", exp_tx_rd, exp_tx_wr);
      end
      checks++;
      if (exp_mw_rd != exp_mw_wr) begin
        errors++;
        $display("FAIL memwr_drain: got %0d writes expected %0d", exp_mw_rd, exp_mw_wr);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic push_rx(input logic [7:0] b);
    rx_mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic send(input logic [7:0] bytes [], input int n);
    for (int i = 0; i < n; i++) push_rx(bytes[i]);
  endtask

  task automatic expect_tx(input logic [7:0] b);
    exp_tx[exp_tx_wr[7:0]] = b;
    exp_tx_wr++;
  endtask

  task automatic expect_mw(input logic [15:0] a, input logic [7:0] d);
    exp_ma[exp_mw_wr[5:0]] = a;
    exp_md[exp_mw_wr[5:0]] = d;
    exp_mw_wr++;
  endtask

  task automatic req(input string n, input logic [63:0] a, input logic [63:0] e);
    req_name[req_wr[6:0]] = n;
    req_act[req_wr[6:0]]  = a;
    req_exp[req_wr[6:0]]  = e;
    req_wr++;
  endtask

  task automatic wait_idle(input string n);
    logic timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (rd_ptr == wr_ptr && exp_tx_rd == exp_tx_wr && exp_mw_rd == exp_mw_wr) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    req(n, 64'(timed_out), 64'd0);
  endtask

  logic [7:0] pkt [];
  int         full_pops, full_pushes;
  logic       to_flag;

  initial begin
    rst = 1'b1; tx_full = 1'b0; parity_err = 1'b0;
    repeat (2) @(negedge clk);
    req("reset_outputs", 64'({rd_en, wr_en, mem_wr, mem_rd, tx_data, mem_addr, mem_wdata, err_code}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Echo of three bytes, then a zero-length echo, then a single byte.
    pkt = '{8'h00, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    send(pkt, 6);
    expect_tx(8'hAA); expect_tx(8'hBB); expect_tx(8'hCC);
    wait_idle("idle_echo3");
    req("err_after_echo", 64'(err_code), 64'd0);
    pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h77};
    send(pkt, 7);
    expect_tx(8'h77);
    wait_idle("idle_echo0");

    // Echo with tx_full held for five cycles mid-stream.
    pkt = '{8'h00, 8'h06, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send(pkt, 9);
    for (int i = 1; i <= 6; i++) expect_tx(8'(i));
    to_flag = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_tx_rd > exp_tx_wr - 6) begin to_flag = 1'b0; break; end
      @(negedge clk);
    end
    req("first_echo_byte_timeout", 64'(to_flag), 64'd0);
    tx_full = 1'b1;
    full_pops = 0; full_pushes = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rd_en) full_pops++;
      if (wr_en && i > 0) full_pushes++;
      @(negedge clk);
    end
    tx_full = 1'b0;
    req("pops_while_full", 64'(full_pops), 64'd0);
    req("pushes_while_full", 64'(full_pushes), 64'd0);
    wait_idle("idle_echo_bp");

    // Write three bytes across the address wrap, then read them back.
    pkt = '{8'h02, 8'hFE, 8'hFF, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    send(pkt, 8);
    expect_mw(16'hFFFE, 8'h11); expect_mw(16'hFFFF, 8'h22); expect_mw(16'h0000, 8'h33);
    wait_idle("idle_memwr");
    pkt = '{8'h01, 8'hFE, 8'hFF, 8'h03, 8'h00};
    send(pkt, 5);
    expect_tx(8'h11); expect_tx(8'h22); expect_tx(8'h33);
    wait_idle("idle_memrd");
    req("err_after_mem", 64'(err_code), 64'd0);

    // Unknown opcode, then clear-on-read of the error register.
    push_rx(8'h7F);
    wait_idle("idle_badop");
    req("err_after_badop", 64'(err_code), 64'd2);
    push_rx(8'h03);
    expect_tx(8'h02);
    wait_idle("idle_errrd1");
    req("err_after_read", 64'(err_code), 64'd0);
    push_rx(8'h03);
    expect_tx(8'h00);
    wait_idle("idle_errrd2");

    // Parity pulse coincident with the error readback push.
    push_rx(8'h7F);
    wait_idle("idle_badop2");
    parity_err = 1'b1;
    @(negedge clk);
    parity_err = 1'b0;
    @(negedge clk);
    req("err_both_bits", 64'(err_code), 64'd3);
    push_rx(8'h03);
    expect_tx(8'h03);
    @(negedge clk);
    parity_err = 1'b1;
    @(negedge clk);
    parity_err = 1'b0;
    wait_idle("idle_errrd3");
    req("err_parity_survives", 64'(err_code), 64'd1);
    push_rx(8'h03);
    expect_tx(8'h01);
    wait_idle("idle_errrd4");
    req("err_final_clear", 64'(err_code), 64'd0);

    // Reset mid-header: no write may follow; echo still works afterwards.
    pkt = '{8'h02, 8'h34, 8'h12};
    send(pkt, 3);
    to_flag = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rd_ptr == wr_ptr) begin to_flag = 1'b0; break; end
      @(negedge clk);
    end
    req("partial_hdr_timeout", 64'(to_flag), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    req("midpkt_reset_outputs", 64'({rd_en, wr_en, mem_wr, mem_rd, tx_data, mem_addr, mem_wdata, err_code}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    pkt = '{8'h00, 8'h01, 8'h00, 8'h5A};
    send(pkt, 4);
    expect_tx(8'h5A);
    wait_idle("idle_after_reset");

    done = 1'b1;
  end

endmodule
